store_queue: RTL

Parametrised, in-order store queue between the AGU and the data cache in the memory system. Holds speculative and committed stores, retires up to COMMIT_W stores per cycle on ROB commit, drains committed stores one at a time to the dcache write port, and answers combinational byte-granular load-forwarding lookups from the load queue. Supersedes the fixed two-commit store buffer with configurable depth, commit width and per-byte youngest-wins forwarding.

---
 rtl/store_queue.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/store_queue.sv
// In-order store queue between AGU and dcache: speculative/committed entries, multi-store
// commit, single-port drain, load lookup. Define STQ_FWD_EN for byte-granular forwarding.
module store_queue #(
  parameter int DEPTH    = 8,
  parameter int COMMIT_W = 2,
  parameter int ADDR_W   = 30,
  parameter int ROB_W    = 5
) (
  input  logic                cpu_clk_i,
  input  logic                cpu_rst_ni,
  input  logic                flush_i,
  input  logic                enq_valid_i,
  output logic                enq_ready_o,
  input  logic [ADDR_W-1:0]   enq_addr_i,
  input  logic [31:0]         enq_data_i,
  input  logic [3:0]          enq_bm_i,
  input  logic                enq_io_i,
  input  logic [ROB_W-1:0]    enq_rob_i,
  output logic                ins_cmp_o,
  output logic [ROB_W-1:0]    ins_rob_o,
  input  logic [COMMIT_W-1:0] commit_i,
  input  logic [ADDR_W-1:0]   lkp_addr_i,
  input  logic [3:0]          lkp_bm_i,
  output logic [31:0]         lkp_data_o,
  output logic [3:0]          lkp_bm_o,
  output logic                lkp_hit_o,
  output logic                lkp_conflict_o,
  output logic                st_valid_o,
  output logic [ADDR_W-1:0]   st_addr_o,
  output logic [31:0]         st_data_o,
  output logic [3:0]          st_bm_o,
  output logic                st_io_o,
  input  logic                st_done_i,
  output logic                empty_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = PTR_W + 2;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [31:0]       data_mem [DEPTH];
  logic [3:0]        bm_mem   [DEPTH];
  logic [DEPTH-1:0]  io_mem;

  logic [PTR_W-1:0] head_reg, cptr_reg, tail_reg;
  logic [PTR_W-1:0] head_next, cptr_next, tail_next;
  logic [PTR_W-1:0] count, uncommitted;
  logic [CNT_W-1:0] commit_cnt;
  logic             full, accept, drain;
  logic             ins_cmp_reg;
  logic [ROB_W-1:0] ins_rob_reg;
  logic [IDX_W-1:0] head_idx, tail_idx;

  assign count       = tail_reg - head_reg;
  assign uncommitted = tail_reg - cptr_reg;
  assign full        = (count == PTR_W'(DEPTH));
  assign head_idx    = head_reg[IDX_W-1:0];
  assign tail_idx    = tail_reg[IDX_W-1:0];

  assign enq_ready_o = ~full;
  assign empty_o     = (head_reg == tail_reg);
  assign st_valid_o  = (head_reg != cptr_reg);
  assign st_addr_o   = addr_mem[head_idx];
  assign st_data_o   = data_mem[head_idx];
  assign st_bm_o     = bm_mem[head_idx];
  assign st_io_o     = io_mem[head_idx];
  assign ins_cmp_o   = ins_cmp_reg;
  assign ins_rob_o   = ins_rob_reg;

  always_comb begin
    commit_cnt = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      commit_cnt = commit_cnt + CNT_W'(commit_i[i]);
    end
  end

  // Commit resolves before flush so a flush never discards stores retiring this cycle.
  always_comb begin
    drain     = st_valid_o & st_done_i;
    accept    = enq_valid_i & ~full & ~flush_i;
    head_next = head_reg + PTR_W'(drain);
    if (commit_cnt > CNT_W'(uncommitted)) begin
      cptr_next = tail_reg;
    end else begin
      cptr_next = cptr_reg + commit_cnt[PTR_W-1:0];
    end
    if (flush_i) begin
      tail_next = cptr_next;
    end else begin
      tail_next = tail_reg + PTR_W'(accept);
    end
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) begin
      head_reg    <= '0;
      cptr_reg    <= '0;
      tail_reg    <= '0;
      ins_cmp_reg <= 1'b0;
      ins_rob_reg <= '0;
    end else begin
      head_reg    <= head_next;
      cptr_reg    <= cptr_next;
      tail_reg    <= tail_next;
      ins_cmp_reg <= accept;
      if (accept) begin
        ins_rob_reg <= enq_rob_i;
      end
    end
  end

  always_ff @(posedge cpu_clk_i) begin
    if (accept) begin
      addr_mem[tail_idx] <= enq_addr_i;
      data_mem[tail_idx] <= enq_data_i;
      bm_mem[tail_idx]   <= enq_bm_i;
      io_mem[tail_idx]   <= enq_io_i;
    end
  end

  // An entry matches a load only if it shares the word and at least one requested byte.
  logic [DEPTH-1:0] ent_valid, ent_match;
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [IDX_W-1:0] age;
    assign age           = IDX_W'(gi) - head_idx;
    assign ent_valid[gi] = ({1'b0, age} < count);
    assign ent_match[gi] = ent_valid[gi] && (addr_mem[gi] == lkp_addr_i) &&
                           (|(bm_mem[gi] & lkp_bm_i));
  end

`ifdef STQ_FWD_EN
  logic [31:0]      fwd_data;
  logic [3:0]       fwd_bm;
  logic [IDX_W-1:0] lkp_slot;
  logic             any_io;

  // Walk oldest to youngest so later writers overwrite earlier ones per byte.
  always_comb begin
    fwd_data = '0;
    fwd_bm   = '0;
    lkp_slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lkp_slot = head_idx + IDX_W'(i);
      if (ent_match[lkp_slot]) begin
        for (int b = 0; b < 4; b++) begin
          if (bm_mem[lkp_slot][b] && lkp_bm_i[b]) begin
            fwd_bm[b]         = 1'b1;
            fwd_data[8*b +: 8] = data_mem[lkp_slot][8*b +: 8];
          end
        end
      end
    end
  end

  assign any_io         = |(ent_match & io_mem);
  assign lkp_data_o     = fwd_data;
  assign lkp_bm_o       = fwd_bm;
  assign lkp_hit_o      = (|ent_match) && (fwd_bm == lkp_bm_i) && !any_io;
  assign lkp_conflict_o = (|ent_match) && !lkp_hit_o;
`else
  assign lkp_data_o     = '0;
  assign lkp_bm_o       = '0;
  assign lkp_hit_o      = 1'b0;
  assign lkp_conflict_o = |ent_match;
`endif

  commit_overflow_a: assert property (@(posedge cpu_clk_i) disable iff (!cpu_rst_ni)
    commit_cnt <= CNT_W'(uncommitted));

endmodule
